// File: rtl/rst_req_wdog.sv
// Frame-activity watchdog driving the active-low reset request.
// Define RST_REQ_WDOG_STATS_EN to add the saturating total_to counter.
module rst_req_wdog #(
  parameter int TIMEOUT   = 3000000,
  parameter int HOLD      = 200,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        wd_en,
  input  logic        vsync,
  input  logic        kick,
  output logic        rst_req_n,
  output logic        timeout,
  output logic        fault,
  output logic [2:0]  wd_state,
`ifdef RST_REQ_WDOG_STATS_EN
  output logic [15:0] total_to,
`endif
  output logic [3:0]  retry_cnt
);

  localparam int CMAX = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
  localparam int CW   = $clog2(CMAX);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(HOLD - 1);
  localparam logic [3:0]    RT_LAST = 4'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_HOLD  = 3'd2,
    S_LOCK  = 3'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_d;
  logic          req_d, to_d, fault_d;
  logic          vsync_d;
  logic          act;

  assign act = (vsync & ~vsync_d) | kick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    req_d   = 1'b1;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (act) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (act) begin
          cnt_d   = '0;
          retry_d = '0;
        end else if (cnt_q == TO_LAST) begin
          to_d  = 1'b1;
          cnt_d = '0;
          if (retry_cnt == RT_LAST) begin
            state_d = S_LOCK;
          end else begin
            retry_d = retry_cnt + 4'd1;
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        req_d = 1'b0;
        // counter only advances once the request is actually low
        if (!rst_req_n) begin
          if (cnt_q == HD_LAST) begin
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOCK: ;
      default: state_d = S_IDLE;
    endcase
    if (!wd_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      retry_d = '0;
      req_d   = 1'b1;
      to_d    = 1'b0;
    end
    fault_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_cnt <= '0;
      rst_req_n <= 1'b1;
      timeout   <= 1'b0;
      fault     <= 1'b0;
      vsync_d   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      rst_req_n <= req_d;
      timeout   <= to_d;
      fault     <= fault_d;
      vsync_d   <= vsync;
    end
  end

  assign wd_state = state_q;

`ifdef RST_REQ_WDOG_STATS_EN
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      total_to <= '0;
    end else if (to_d && (total_to != 16'hFFFF)) begin
      total_to <= total_to + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rst_req_wdog.sv
// Bench for rst_req_wdog: cycle-timestamp model plus directed scenarios.
module tb_rst_req_wdog;
  localparam int TO = 50;
  localparam int HD = 130;
  localparam int MR = 2;

  logic clk_100 = 1'b0;
  logic rst_n = 1'b0;
  logic wd_en = 1'b0;
  logic vsync = 1'b0;
  logic kick = 1'b0;
  logic rst_req_n, timeout, fault;
  logic [2:0] wd_state;
  logic [3:0] retry_cnt;
`ifdef RST_REQ_WDOG_STATS_EN
  logic [15:0] total_to;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_100 = ~clk_100;

  rst_req_wdog #(.TIMEOUT(TO), .HOLD(HD), .MAX_RETRY(MR)) dut (
    .clk_100(clk_100),
    .rst_n(rst_n),
    .wd_en(wd_en),
    .vsync(vsync),
    .kick(kick),
    .rst_req_n(rst_req_n),
    .timeout(timeout),
    .fault(fault),
    .wd_state(wd_state),
`ifdef RST_REQ_WDOG_STATS_EN
    .total_to(total_to),
`endif
    .retry_cnt(retry_cnt)
  );

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, a, e, $time);
    end
  endtask

  // Model: mode 0 idle, 1 armed, 2 hold, 3 lockout; times are edge numbers
  int m_n = 0, m_mode = 0, m_since = 0, m_retry = 0, m_total = 0;
  int m_low_from = 0, m_low_until = 0;
  bit m_to = 0, m_pv = 0;

  initial forever begin
    @(posedge clk_100 or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_retry = 0; m_to = 0; m_pv = 0; m_total = 0;
    end else begin
      bit act;
      act = (vsync && !m_pv) || kick;
      m_pv = vsync;
      m_n++;
      m_to = 0;
      if (!wd_en) begin
        m_mode = 0; m_retry = 0;
      end else begin
        case (m_mode)
          0: if (act) begin m_mode = 1; m_since = m_n; end
          1: if (act) begin
               m_since = m_n; m_retry = 0;
             end else if (m_n - m_since == TO) begin
               m_to = 1;
               if (m_total < 65535) m_total++;
               if (m_retry + 1 == MR) m_mode = 3;
               else begin
                 m_retry++; m_mode = 2;
                 m_low_from = m_n + 1; m_low_until = m_n + 1 + HD;
               end
             end
          2: if (m_n == m_low_until) begin m_mode = 1; m_since = m_n; end
          default: ;
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clk_100);
    chk("state", wd_state, m_mode);
    chk("rst_req_n", rst_req_n, !(m_mode == 2 && m_n >= m_low_from));
    chk("timeout", timeout, m_to);
    chk("fault", fault, m_mode == 3);
    chk("retry_cnt", retry_cnt, m_retry);
`ifdef RST_REQ_WDOG_STATS_EN
    chk("total_to", total_to, m_total);
`endif
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk_100);
  endtask

  task automatic arm();
    @(negedge clk_100); vsync = 1'b1;
    @(negedge clk_100); vsync = 1'b0;
  endtask

  task automatic wait_for(input string name, input int sel,
                          input logic val, input int bound, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk_100);
      n++;
      s = (sel == 0) ? timeout : rst_req_n;
    end while (s !== val && n < bound);
    if (s !== val) chk({name, "_bound"}, s, val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got expired, want finish");
    $fatal(1);
  end

  initial begin
    int n, seen;
    step(3);
    chk("rst_state", wd_state, 0);
    chk("rst_req", rst_req_n, 1);
    chk("rst_to", timeout, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_cnt, 0);
    @(negedge clk_100); rst_n = 1'b1; wd_en = 1'b1;

    seen = 0;
    repeat (500) begin
      @(negedge clk_100);
      if (timeout || wd_state != 3'd0 || !rst_req_n) seen++;
    end
    chk("s1_idle_quiet", seen, 0);

    seen = 0;
    repeat (50) begin
      arm();
      repeat (38) begin
        @(negedge clk_100);
        if (timeout || !rst_req_n || retry_cnt != 4'd0) seen++;
      end
    end
    chk("s2_no_timeout", seen, 0);
    chk("s2_armed", wd_state, 1);

    @(negedge clk_100); wd_en = 1'b0;
    @(negedge clk_100); wd_en = 1'b1;
    arm();
    wait_for("s3_to", 0, 1'b1, 200, n);
    chk("s3_to_delay", n, 50);
    chk("s3_retry", retry_cnt, 1);
    wait_for("s3_low", 1, 1'b0, 5, n);
    chk("s3_low_start", n, 1);
    wait_for("s3_high", 1, 1'b1, 400, n);
    chk("s3_low_len", n, 130);
    chk("s3_rearmed", wd_state, 1);
    chk("s3_retry_kept", retry_cnt, 1);

    wait_for("s4_to", 0, 1'b1, 200, n);
    chk("s4_to_delay", n, 50);
    chk("s4_lock_state", wd_state, 3);
    chk("s4_fault", fault, 1);
    seen = 0;
    repeat (200) begin
      @(negedge clk_100);
      if (!rst_req_n) seen++;
    end
    chk("s4_no_low", seen, 0);
    chk("s4_still_lock", wd_state, 3);
    wd_en = 1'b0;
    @(negedge clk_100);
    chk("s4_idle", wd_state, 0);
    chk("s4_fault_clr", fault, 0);
    wd_en = 1'b1;

    arm();
    step(49);
    kick = 1'b1;
    @(negedge clk_100); kick = 1'b0;
    chk("s5_kick_wins", timeout, 0);
    wait_for("s5_to", 0, 1'b1, 200, n);
    chk("s5_to_delay", n, 50);

    wait_for("s6_low", 1, 1'b0, 5, n);
    step(59);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_req_async", rst_req_n, 1);
    chk("s6_state", wd_state, 0);
    chk("s6_retry", retry_cnt, 0);
    chk("s6_fault", fault, 0);
    chk("s6_to", timeout, 0);
    @(negedge clk_100); rst_n = 1'b1;

    arm();
    wait_for("s7_to", 0, 1'b1, 200, n);
    wait_for("s7_low", 1, 1'b0, 5, n);
    step(59);
    wd_en = 1'b0;
    @(negedge clk_100);
    chk("s7_req_hi", rst_req_n, 1);
    chk("s7_idle", wd_state, 0);
    chk("s7_retry", retry_cnt, 0);
    wd_en = 1'b1;
    arm();
    wait_for("s7_to2", 0, 1'b1, 200, n);
    chk("s7_to2_delay", n, 50);
`ifdef RST_REQ_WDOG_STATS_EN
    chk("s7_total", total_to, 2);
`endif
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
